// File: rtl/top_cpu_debug_scan_master.sv
// Scan-side initiator for the Nios II debug slave virtual-JTAG interface (2-bit IR, 38-bit DR).
// One command per handshake: walks UIR/CDR/SDR/UDR/RTI, shifts the DR LSB-first on vji_tdi and
// returns the captured vji_tdo bits.
// Optional build macro SCAN_SKIP_IR_EN: skip the UIR period when the IR repeats the last one.
module top_cpu_debug_scan_master #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned     BitW    = $clog2(DR_WIDTH);
    localparam logic [BitW-1:0] BitLast = BitW'(DR_WIDTH - 1);
    localparam logic [BitW-1:0] BitOne  = BitW'(1);
    localparam logic [7:0]      DivLast = 8'(TCK_DIV - 1);
    localparam logic [7:0]      DivOne  = 8'd1;

    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StSdr,
        StUdr,
        StRti,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                alive_q;
    logic [7:0]          div_q;
    logic                phase_q;
    logic [BitW-1:0]     bit_q;
    logic [DR_WIDTH-1:0] sh_q;
    logic                tdi_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;
    logic                rsp_valid_q;

    logic scanning;
    logic half_end;
    logic period_end;
    logic tck_rise;
    logic accept;
    logic skip_ir;

    assign scanning   = (state_q != StIdle) && (state_q != StResp);
    assign half_end   = (div_q == DivLast);
    assign period_end = scanning && half_end && phase_q;
    assign tck_rise   = scanning && half_end && !phase_q;
    assign cmd_ready  = alive_q && (state_q == StIdle) && !rsp_valid_q;
    assign accept     = cmd_valid && cmd_ready;

`ifdef SCAN_SKIP_IR_EN
    logic [IR_WIDTH-1:0] last_ir_q;
    logic                last_ir_vld_q;

    // Remember the IR of the most recently accepted command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ir_q     <= '0;
            last_ir_vld_q <= 1'b0;
        end else if (accept) begin
            last_ir_q     <= cmd_ir;
            last_ir_vld_q <= 1'b1;
        end
    end

    assign skip_ir = last_ir_vld_q && (cmd_ir == last_ir_q);
`else
    assign skip_ir = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every scan state lasts whole tck periods.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = skip_ir ? StCdr : StUir;
            StUir:   if (period_end) state_d = StCdr;
            StCdr:   if (period_end) state_d = StSdr;
            StSdr:   if (period_end && (bit_q == BitLast)) state_d = StUdr;
            StUdr:   if (period_end) state_d = StRti;
            StRti:   if (period_end) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Keeps cmd_ready low until the first clk after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // Scan clock divider: each period is TCK_DIV clks low followed by TCK_DIV clks high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else if (!scanning) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else if (half_end) begin
            div_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            div_q <= div_q + DivOne;
        end
    end

    // Command latch and serial data out; tdi changes only at the start of a low phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q  <= '0;
            sh_q  <= '0;
            tdi_q <= 1'b0;
            bit_q <= '0;
        end else begin
            if (accept) begin
                ir_q <= cmd_ir;
                sh_q <= cmd_data;
            end
            if (period_end && ((state_q == StCdr) ||
                               ((state_q == StSdr) && (bit_q != BitLast)))) begin
                tdi_q <= sh_q[0];
                sh_q  <= sh_q >> 1;
            end else if (period_end && (state_q == StSdr)) begin
                tdi_q <= 1'b0;
            end
            if (state_q != StSdr) begin
                bit_q <= '0;
            end else if (period_end) begin
                bit_q <= bit_q + BitOne;
            end
        end
    end

    // Capture tdo on tck rise, latch IR status at end of CDR, hold the response until taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data_q  <= '0;
            rsp_ir_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (tck_rise && (state_q == StSdr)) begin
                rsp_data_q <= {vji_tdo, rsp_data_q[DR_WIDTH-1:1]};
            end
            if (period_end && (state_q == StCdr)) begin
                rsp_ir_q <= vji_ir_out;
            end
            if (state_q == StResp) begin
                rsp_valid_q <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ir_out = rsp_ir_q;
    assign vji_tck    = phase_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_q;
    assign vji_uir    = (state_q == StUir);
    assign vji_cdr    = (state_q == StCdr);
    assign vji_sdr    = (state_q == StSdr);
    assign vji_udr    = (state_q == StUdr);
    assign vji_rti    = (state_q == StRti);

endmodule

// File: tb/tb_top_cpu_debug_scan_master.sv
// Scoreboard bench for top_cpu_debug_scan_master: the stimulus pushes the expected response,
// and a monitor pops and compares each time rsp_valid rises.
`timescale 1ns/1ps
module tb_top_cpu_debug_scan_master;

    localparam int DW = 38;
    localparam int IW = 2;
    localparam int TD = 4;
    localparam int unsigned LatFull = 1 + (DW + 4) * 2 * TD;
    localparam int unsigned LatSkip = LatFull - 2 * TD;
`ifdef SCAN_SKIP_IR_EN
    localparam bit SkipEn = 1'b1;
`else
    localparam bit SkipEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_ir;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [IW-1:0] rsp_ir_out;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [IW-1:0] vji_ir_in, vji_ir_out;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    top_cpu_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low.
    logic [1:0] tdo_mode = 2'd0;
    assign vji_tdo = (tdo_mode == 2'd0) ? vji_tdi :
                     (tdo_mode == 2'd1) ? ~vji_tdi : (tdo_mode == 2'd2);

    logic rdy_rand  = 1'b1;
    logic rdy_force = 1'b0;
    logic rdy_rnd   = 1'b1;
    always @(negedge clk) rdy_rnd <= ($urandom_range(0, 3) != 0);
    assign rsp_ready = rdy_rand ? rdy_rnd : rdy_force;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] ir_out;
        logic [IW-1:0] ir_in;
        logic [DW-1:0] tdi_seq;
        int unsigned   due;
        bit            uir;
    } exp_t;

    exp_t          sb[$];
    bit            last_v = 1'b0;
    logic [IW-1:0] last_ir = '0;
    int unsigned   acc_edge = 0;
    int unsigned   cons_edge = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_rsp(input logic [1:0] mode, input logic [DW-1:0] d);
        case (mode)
            2'd0:    return d;
            2'd1:    return ~d;
            2'd2:    return '1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Monitor: scan observation plus scoreboard pop on every rising rsp_valid.
    int unsigned   nrise = 0;
    int unsigned   rsp_rises = 0;
    bit            uir_seen = 1'b0, tdi_bad = 1'b0, prev_tck = 1'b0, prev_valid = 1'b0;
    logic [DW-1:0] tdi_word = '0, held_data = '0;
    logic [IW-1:0] held_ir = '0;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            nrise      = 0;
            uir_seen   = 1'b0;
            tdi_bad    = 1'b0;
            prev_tck   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (vji_uir) uir_seen = 1'b1;
            if (!vji_sdr && vji_tdi) tdi_bad = 1'b1;
            if (vji_tck && !prev_tck && vji_sdr) begin
                tdi_word = {vji_tdi, tdi_word[DW-1:1]};
                nrise++;
            end
            if (rsp_valid && !prev_valid) begin
                rsp_rises++;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                    chk("rsp_ir_out", 64'(rsp_ir_out), 64'(mon_e.ir_out));
                    chk("latency", 64'(cyc), 64'(mon_e.due));
                    chk("uir_pulse", 64'(uir_seen), 64'(mon_e.uir));
                    chk("sdr_tck_rises", 64'(nrise), 64'(DW));
                    chk("tdi_sequence", 64'(tdi_word), 64'(mon_e.tdi_seq));
                    chk("tdi_zero_outside_sdr", 64'(tdi_bad), 64'd0);
                    chk("vji_ir_in", 64'(vji_ir_in), 64'(mon_e.ir_in));
                end
                held_data = rsp_data;
                held_ir   = rsp_ir_out;
                nrise     = 0;
                uir_seen  = 1'b0;
                tdi_bad   = 1'b0;
            end else if (rsp_valid) begin
                chk("rsp_data_stable", 64'(rsp_data), 64'(held_data));
                chk("rsp_ir_stable", 64'(rsp_ir_out), 64'(held_ir));
            end
            prev_tck   = vji_tck;
            prev_valid = rsp_valid;
        end
    end

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    task automatic send(input logic [IW-1:0] ir, input logic [DW-1:0] data,
                        input logic [1:0] mode, input logic [IW-1:0] irout);
        exp_t        e;
        bit          skip;
        int unsigned n;
        drain();
        @(negedge clk);
        tdo_mode   = mode;
        vji_ir_out = irout;
        cmd_ir     = ir;
        cmd_data   = data;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        skip      = SkipEn && last_v && (ir == last_ir);
        last_v    = 1'b1;
        last_ir   = ir;
        acc_edge  = cyc + 1;
        e.data    = model_rsp(mode, data);
        e.ir_out  = irout;
        e.ir_in   = ir;
        e.tdi_seq = data;
        e.due     = acc_edge + (skip ? LatSkip : LatFull);
        e.uir     = !skip;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = rnd_data();
        cmd_ir    = IW'($urandom());
    endtask

    int unsigned n_wait;
    int unsigned rises_before;

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_ir     = 2'b11;
        cmd_data   = '1;
        vji_ir_out = '0;

        // Reset with cmd_valid held.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_data, rsp_ir_out, vji_tck, vji_tdi,
                                  vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        #1 reset_n = 1'b1;
        #1 chk("ready_at_release", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("ready_one_clk_after", 64'(cmd_ready), 64'd1);
        chk("tck_idle", 64'(vji_tck), 64'd0);
        cmd_valid = 1'b0;

        // Alternating pattern through loopback; tied-high tdo with IR status 2'b10.
        send(2'b01, 38'h2A_AAAA_AAAA, 2'd0, 2'b01);
        send(2'b11, rnd_data(), 2'd2, 2'b10);
        // Repeated IR: UIR skipped on the second scan when the skip feature is built in.
        send(2'b10, rnd_data(), 2'd1, 2'b01);
        send(2'b10, rnd_data(), 2'd0, 2'b11);

        // Response held for 50 clks while the next command waits.
        drain();
        rdy_force = 1'b0;
        rdy_rand  = 1'b0;
        send(2'b00, rnd_data(), 2'd0, 2'b10);
        fork
            send(2'b01, rnd_data(), 2'd3, 2'b01);
            begin
                n_wait = 0;
                while (!rsp_valid && n_wait < 3000) begin
                    @(negedge clk);
                    n_wait++;
                end
                chk("stall_rsp_seen", 64'(rsp_valid), 64'd1);
                for (int i = 0; i < 50; i++) begin
                    chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
                    @(negedge clk);
                end
                rdy_force = 1'b1;
                cons_edge = cyc + 1;
                @(negedge clk);
                rdy_force = 1'b0;
            end
        join
        chk("accept_after_consume", 64'(acc_edge), 64'(cons_edge + 1));
        rdy_rand = 1'b1;

        // Random commands with random slave behaviour and backpressure.
        for (int k = 0; k < 14; k++) begin
            send(IW'($urandom()), rnd_data(), 2'($urandom()), IW'($urandom()));
        end

        // Reset in the middle of SDR bit 17.
        send(2'b01, rnd_data(), 2'd0, 2'b10);
        n_wait = 0;
        while (!(vji_sdr && nrise == 17) && n_wait < 3000) begin
            @(negedge clk);
            n_wait++;
        end
        chk("reached_sdr_bit17", 64'(nrise), 64'd17);
        #2 reset_n = 1'b0;
        #1 chk("abort_outputs", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tck,
                                     vji_tdi, rsp_valid, cmd_ready}), 64'd0);
        sb.delete();
        last_v = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        rises_before = rsp_rises;
        repeat (400) @(negedge clk);
        chk("no_rsp_after_abort", 64'(rsp_rises), 64'(rises_before));

        // Normal scans after the abort.
        send(2'b11, 38'h15_5555_5555, 2'd0, 2'b01);
        send(2'b11, rnd_data(), 2'd1, 2'b00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
